// File: rtl/excess3_ser_tx_if.sv
// rtl/excess3_ser_tx_if.sv - digit load handshake and serial frame outputs of the excess-3 transmitter
interface excess3_ser_tx_if;
  logic [3:0] din;
  logic       load;
  logic       ready;
  logic       x;
  logic       valid;
  logic       sof;
  logic       err;
  logic       err_clr;

  modport master (
    output din, load, err_clr,
    input  ready, x, valid, sof, err
  );

  modport slave (
    input  din, load, err_clr,
    output ready, x, valid, sof, err
  );
endinterface

// File: rtl/excess3_ser_tx.sv
// rtl/excess3_ser_tx.sv - excess-3 encoder with one-deep hold and LSB-first 4-bit serial framer
module excess3_ser_tx #(
  parameter int unsigned OFFSET    = 3,
  parameter int unsigned MAX_DIGIT = 9,
  parameter int unsigned GAP       = 0
) (
  input logic            clk,
  input logic            reset,
  excess3_ser_tx_if.slave bus
);

  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [2:0] GAP_LAST = 3'(HAS_GAP ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;

  state_t     state;
  logic [3:0] shift;
  logic [3:0] hold;
  logic       hold_full;
  logic [1:0] bit_cnt;
  logic [2:0] gap_cnt;
  logic       x_q;
  logic       valid_q;
  logic       sof_q;
  logic       err_q;

  logic       accept;
  logic       legal;
  logic [3:0] code;
  logic       boundary;
  logic       next_avail;
  logic [3:0] next_code;
  logic       launch;

  assign accept = bus.load && !hold_full;
  assign legal  = ({28'd0, bus.din} <= MAX_DIGIT);
  assign code   = bus.din + 4'(OFFSET);

  // A frame may start at any point where the line is free: idle, the last bit
  // of a frame when no gap is configured, or the last gap cycle. A digit
  // accepted on that very edge goes straight to the shifter, bypassing hold.
  assign boundary = (state == IDLE)
                 || (state == SHIFT && bit_cnt == 2'd3 && !HAS_GAP)
                 || (state == GAP_WAIT && gap_cnt == GAP_LAST);
  assign next_avail = hold_full || (accept && legal);
  assign next_code  = hold_full ? hold : code;
  assign launch     = boundary && next_avail;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= 4'd0;
      hold      <= 4'd0;
      hold_full <= 1'b0;
      bit_cnt   <= 2'd0;
      gap_cnt   <= 3'd0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept && !legal) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end

      if (launch) begin
        hold_full <= 1'b0;
      end else if (accept && legal) begin
        hold      <= code;
        hold_full <= 1'b1;
      end

      if (launch) begin
        x_q     <= next_code[0];
        shift   <= {1'b0, next_code[3:1]};
        bit_cnt <= 2'd0;
        valid_q <= 1'b1;
        sof_q   <= 1'b1;
        state   <= SHIFT;
      end else begin
        case (state)
          IDLE: begin
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
          end
          SHIFT: begin
            sof_q <= 1'b0;
            if (bit_cnt == 2'd3) begin
              x_q     <= 1'b0;
              valid_q <= 1'b0;
              gap_cnt <= 3'd0;
              state   <= HAS_GAP ? GAP_WAIT : IDLE;
            end else begin
              x_q     <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 2'd1;
              valid_q <= 1'b1;
            end
          end
          GAP_WAIT: begin
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 3'd1;
            end
          end
          default: begin
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ready = !hold_full;
  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.sof   = sof_q;
  assign bus.err   = err_q;

endmodule
